// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer, flush, and a saturating stall counter.
// in_ready is derived only from registered state, so it never depends on out_ready in the same cycle.
module pipe_stage_skid #(
  parameter int DATA_W        = 64,
  parameter int CNT_W         = 16,
  parameter bit ZERO_ON_EMPTY = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  // Handshake: a beat moves on an edge where valid & ready are both high;
  // a producer holding valid must keep its data stable until that edge.
  logic              main_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              accept;
  logic              pop;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign accept    = in_valid & in_ready;
  assign pop       = main_valid & out_ready;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  always_comb begin
    out_data = main_data;
    if (ZERO_ON_EMPTY && !main_valid) out_data = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid  <= 1'b0;
      skid_valid  <= 1'b0;
      main_data   <= '0;
      skid_data   <= '0;
      stall_count <= '0;
    end else if (flush) begin
      // Any same-cycle accept is dropped; the stall counter keeps its value.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else begin
      if (main_valid && !out_ready && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;

      if (!main_valid) begin
        if (accept) begin
          main_data  <= in_data;
          main_valid <= 1'b1;
        end
      end else if (!skid_valid) begin
        if (accept && pop) begin
          main_data <= in_data;
        end else if (accept) begin
          skid_data  <= in_data;
          skid_valid <= 1'b1;
        end else if (pop) begin
          main_valid <= 1'b0;
        end
      end else if (pop) begin
        // Skid entry is older than anything upstream, so it refills main first.
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: three instances share stimulus and differ in
// ZERO_ON_EMPTY and counter width.
module tb_pipe_stage_skid;

  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          in_ready,  in_ready0,  in_ready_s;
  logic          out_valid, out_valid0, out_valid_s;
  logic [DW-1:0] out_data,  out_data0,  out_data_s;
  logic [1:0]    occupancy, occupancy0, occupancy_s;
  logic [15:0]   stall_count, stall_count0;
  logic [3:0]    stall_count_s;

  int checks   = 0;
  int failures = 0;

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(16), .ZERO_ON_EMPTY(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_count(stall_count));

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(16), .ZERO_ON_EMPTY(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occupancy0), .stall_count(stall_count0));

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(4), .ZERO_ON_EMPTY(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .occupancy(occupancy_s), .stall_count(stall_count_s));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (stall_count !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_count); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== DW'(i))
        begin failures++; $display("FAIL stream_data[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, DW'(i)); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0)
      begin failures++; $display("FAIL stream_drain got=%b/%h exp=0/0000", out_valid, out_data); end
    checks++; if (stall_count !== 16'd0) begin failures++; $display("FAIL stream_stall got=%0d exp=0", stall_count); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0010;
    step();
    checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1)
      begin failures++; $display("FAIL bp_one got occ=%0d rdy=%b exp occ=1 rdy=1", occupancy, in_ready); end
    in_data = 16'h0011;
    step();
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0)
      begin failures++; $display("FAIL bp_full got occ=%0d rdy=%b exp occ=2 rdy=0", occupancy, in_ready); end
    in_data = 16'h0012;
    step();
    checks++; if (occupancy !== 2'd2 || out_data !== 16'h0010)
      begin failures++; $display("FAIL bp_hold got occ=%0d data=%h exp occ=2 data=0010", occupancy, out_data); end
    out_ready = 1'b1;
    step();
    checks++; if (out_data !== 16'h0011 || in_ready !== 1'b1)
      begin failures++; $display("FAIL bp_pop1 got data=%h rdy=%b exp data=0011 rdy=1", out_data, in_ready); end
    step();
    checks++; if (out_data !== 16'h0012 || occupancy !== 2'd1)
      begin failures++; $display("FAIL bp_pop2 got data=%h occ=%0d exp data=0012 occ=1", out_data, occupancy); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      begin failures++; $display("FAIL bp_drain got valid=%b occ=%0d exp 0/0", out_valid, occupancy); end
    checks++; if (stall_count !== 16'd2) begin failures++; $display("FAIL bp_stall got=%0d exp=2", stall_count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h00A1;
    step();
    in_data = 16'h00A2;
    step();
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL flush_fill got=%0d exp=2", occupancy); end
    flush = 1'b1; in_data = 16'h0055; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 16'h0)
      begin failures++; $display("FAIL flush_empty got v=%b occ=%0d d=%h exp 0/0/0000", out_valid, occupancy, out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0 || out_data0 === 16'h0055)
        begin failures++; $display("FAIL flush_no_55[%0d] got v=%b d0=%h exp v=0 d0!=0055", i, out_valid, out_data0); end
    end
    checks++; if (stall_count !== 16'd3) begin failures++; $display("FAIL flush_stall got=%0d exp=3", stall_count); end
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0077;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid0 !== 1'b1 || out_data0 !== 16'h0077)
      begin failures++; $display("FAIL bubble_load got v=%b d=%h exp 1/0077", out_valid0, out_data0); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid0 !== 1'b0 || out_data0 !== 16'h0077)
      begin failures++; $display("FAIL bubble_hold got v=%b d=%h exp 0/0077", out_valid0, out_data0); end
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0)
      begin failures++; $display("FAIL bubble_zero got v=%b d=%h exp 0/0000", out_valid, out_data); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h000A;
    step();
    in_data = 16'h000B;
    step();
    in_valid = 1'b0;
    checks++; if (occupancy !== 2'd2 || stall_count !== 16'd4)
      begin failures++; $display("FAIL rst_mid_pre got occ=%0d st=%0d exp 2/4", occupancy, stall_count); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0 || occupancy !== 2'd0 || in_ready !== 1'b1)
      begin failures++; $display("FAIL rst_mid_async got v=%b d=%h occ=%0d rdy=%b exp 0/0000/0/1", out_valid, out_data, occupancy, in_ready); end
    checks++; if (stall_count !== 16'd0 || out_data0 !== 16'h0)
      begin failures++; $display("FAIL rst_mid_regs got st=%0d d0=%h exp 0/0000", stall_count, out_data0); end
    #1 reset = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h003C;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    checks++; if (stall_count_s !== 4'd15)
      begin failures++; $display("FAIL sat_reach got=%0d exp=15", stall_count_s); end
    for (int i = 0; i < 5; i++) step();
    checks++; if (stall_count_s !== 4'd15)
      begin failures++; $display("FAIL sat_hold got=%0d exp=15", stall_count_s); end
    checks++; if (stall_count !== 16'd20)
      begin failures++; $display("FAIL sat_wide got=%0d exp=20", stall_count); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble();
    test_reset_midstream();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register; the generalised successor of the fixed-field IF/ID latch.
- Carries an arbitrary DATA_W payload (instruction fields, PC, control bundle) between two pipeline stages using a valid/ready handshake.
- A 2-entry skid buffer registers backpressure without losing data. Supports flush (bubble insertion) and reports a saturating stall-cycle counter.
- Instantiated between every pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 64: payload width in bits.
- CNT_W, 16: width of the stall counter.
- ZERO_ON_EMPTY, 1: 1 = out_data forced to all-zero whenever out_valid=0 (bubble reads as NOP); 0 = out_data holds the last value.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of all held entries; flush has priority over everything except reset.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream consumes this cycle.
- out_data  output  DATA_W  payload to downstream.
- occupancy  output  2  number of held entries, 0..2.
- stall_count  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
Reset values:
- Asserting reset at any time, including mid-transfer, immediately clears main_valid, skid_valid, main_data, skid_data and stall_count to 0.
- Therefore out_valid=0, out_data=0, occupancy=0, in_ready=1, stall_count=0.

Storage:
- main register (drives out_data) and skid register, each holding data plus a valid bit.
- State is encoded by the valid bits:
  - EMPTY: no entries.
  - ONE: main valid only.
  - FULL: main and skid both valid.

Handshake:
- in_ready = !skid_valid. It is a register output only; there is no combinational path from out_ready to in_ready.
- accept = in_valid & in_ready.
- pop = out_valid & out_ready.
- out_valid = main_valid.

Transitions (no flush):
- EMPTY:
  - accept -> ONE, main <= in_data.
- ONE:
  - accept & pop -> ONE, main <= in_data.
  - accept & !pop -> FULL, skid <= in_data.
  - !accept & pop -> EMPTY.
  - otherwise hold.
- FULL (in_ready=0, so no accept):
  - pop -> ONE, main <= skid, skid_valid <= 0.
  - otherwise hold.

Latency and throughput:
- Data accepted at edge N is visible on out_data after edge N, one cycle later.
- With out_ready held at 1: one transfer per cycle, zero bubbles.

Ordering:
- Strict FIFO order.
- The skid entry always precedes any later input.

Flush:
- When flush=1 at an edge: main_valid <= 0, skid_valid <= 0, and the data registers are zeroed.
- Any simultaneous accept is discarded: the input is dropped and the upstream sees it as consumed.
- A simultaneous pop completes from downstream's view; the data was presented, and the consumer decides.
- Next cycle: EMPTY, in_ready=1.

ZERO_ON_EMPTY:
- When 1: out_data = main_valid ? main_data : 0.
- When 0: out_data = main_data always.

occupancy:
- main_valid + skid_valid.
- Registered-derived; updates the cycle after the event.

stall_count:
- Increments by 1 on each edge where out_valid & !out_ready & !flush.
- Saturates at 2^CNT_W-1; never wraps.
- Cleared only by reset.

Simultaneous events:
- Priority: reset > flush > accept/pop.
- in_valid while FULL is ignored; upstream must hold in_data until in_ready.

Test Plan:
- Reset mid-stream: while FULL with data 0xA,0xB, assert reset asynchronously -> out_valid=0, out_data=0, occupancy=0, in_ready=1 immediately, without waiting for a clock edge.
- Streaming: out_ready=1, push 0x1..0x8 on consecutive cycles -> out_data=0x1..0x8 on consecutive cycles, each one cycle after accept; in_ready stays 1; stall_count=0.
- Backpressure/skid: push 0x10,0x11,0x12 back-to-back with out_ready=0 -> 0x10 in main, 0x11 in skid, in_ready=0 after second accept, occupancy=2, 0x12 not taken. Release out_ready -> outputs 0x10,0x11,0x12 in order, no loss or duplication; stall_count = number of stalled cycles.
- Flush collision: in FULL, assert flush together with in_valid=1 (0x55) and out_ready=1 -> next cycle out_valid=0, occupancy=0, out_data=0 (ZERO_ON_EMPTY=1), 0x55 never appears.
- Bubble value: ZERO_ON_EMPTY=0, pop the last entry 0x77 -> out_valid=0, out_data stays 0x77. Repeat with ZERO_ON_EMPTY=1 -> out_data=0.
- Counter saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_count reaches 15 and stays at 15; no wrap to 0.
